// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the HD44780 bus sequencer.
// Default timings assume a 50 MHz clk.
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } seq_state_e;

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;

  localparam int unsigned DEF_T_AS        = 4;
  localparam int unsigned DEF_T_PW        = 25;
  localparam int unsigned DEF_T_H         = 2;
  localparam int unsigned DEF_T_EXEC      = 2000;
  localparam int unsigned DEF_T_EXEC_LONG = 82000;
  localparam int unsigned DEF_CNT_W       = 17;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_cmd_t;

  // Clear Display / Return Home (and their don't-care alias 0x03) need the long wait
  function automatic logic is_long_instr(lcd_cmd_t c);
    return !c.rs && !c.rw && ((c.data & ~(LCD_CLEAR | LCD_HOME)) == 8'h00) &&
           (c.data != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter; holds at zero and flags it combinationally.
module lcd_delay_counter #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero_c
);

  logic [CNT_W-1:0] value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - CNT_W'(1);
    end
  end

  assign zero_c = (value == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Generates HD44780 RS/RW setup, E pulse, hold and execution delay for one
// command/data transfer at a time; returns the sampled byte on reads.
module lcd_bus_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned T_AS        = DEF_T_AS,
  parameter int unsigned T_PW        = DEF_T_PW,
  parameter int unsigned T_H         = DEF_T_H,
  parameter int unsigned T_EXEC      = DEF_T_EXEC,
  parameter int unsigned T_EXEC_LONG = DEF_T_EXEC_LONG,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe,
  input  logic [7:0] LCD_data_in
);

  localparam logic [CNT_W-1:0] AS_M1   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] PW_M1   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] H_M1    = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] EXEC_M1 = CNT_W'((T_EXEC == 0) ? 0 : T_EXEC - 1);
  localparam logic [CNT_W-1:0] LONG_M1 = CNT_W'((T_EXEC_LONG == 0) ? 0 : T_EXEC_LONG - 1);

  seq_state_e       state;
  lcd_cmd_t         cmd;
  logic             accept;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero_c;
  logic             exec_skip;
  logic [CNT_W-1:0] exec_m1;
  logic             next_skip;
  logic [CNT_W-1:0] next_exec_m1;

  assign cmd    = '{rs: cmd_rs, rw: cmd_rw, data: cmd_data};
  assign accept = cmd_valid && cmd_ready;

  // Execution wait for the command being offered; busy reads need none
  always_comb begin
    next_skip    = 1'b0;
    next_exec_m1 = EXEC_M1;
    if (!cmd.rs && cmd.rw) begin
      next_skip = 1'b1;
    end else if (is_long_instr(cmd)) begin
      next_skip    = (T_EXEC_LONG == 0);
      next_exec_m1 = LONG_M1;
    end else begin
      next_skip = (T_EXEC == 0);
    end
  end

  // Counter is reloaded with (length - 1) on every phase entry
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_load  = 1'b1;
          cnt_value = AS_M1;
        end
      end
      SETUP: begin
        if (cnt_zero_c) begin
          cnt_load  = 1'b1;
          cnt_value = PW_M1;
        end
      end
      PULSE: begin
        if (cnt_zero_c) begin
          cnt_load  = 1'b1;
          cnt_value = H_M1;
        end
      end
      HOLD: begin
        if (cnt_zero_c && !exec_skip) begin
          cnt_load  = 1'b1;
          cnt_value = exec_m1;
        end
      end
      default: begin
        cnt_load  = 1'b0;
        cnt_value = '0;
      end
    endcase
  end

  lcd_delay_counter #(
    .CNT_W(CNT_W)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .load      (cnt_load),
    .load_value(cnt_value),
    .zero_c    (cnt_zero_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      LCD_E        <= 1'b0;
      LCD_RS       <= 1'b0;
      LCD_RW       <= 1'b0;
      LCD_data_out <= 8'h00;
      LCD_data_oe  <= 1'b0;
      exec_skip    <= 1'b0;
      exec_m1      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state        <= SETUP;
            cmd_ready    <= 1'b0;
            LCD_E        <= 1'b0;
            LCD_RS       <= cmd.rs;
            LCD_RW       <= cmd.rw;
            LCD_data_out <= cmd.data;
            LCD_data_oe  <= ~cmd.rw;
            exec_skip    <= next_skip;
            exec_m1      <= next_exec_m1;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_zero_c) begin
            state <= PULSE;
            LCD_E <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_zero_c) begin
            state <= HOLD;
            LCD_E <= 1'b0;
            if (LCD_RW) begin
              rsp_data  <= LCD_data_in;
              rsp_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt_zero_c) begin
            if (exec_skip) begin
              state       <= IDLE;
              cmd_ready   <= 1'b1;
              LCD_data_oe <= 1'b0;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt_zero_c) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            LCD_data_oe <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Scoreboard bench for lcd_bus_sequencer: driver queues expected transfers,
// a cycle monitor checks the pin timeline derived from the timing rules.
module tb_lcd_bus_sequencer;

  localparam int unsigned T_AS        = 2;
  localparam int unsigned T_PW        = 3;
  localparam int unsigned T_H         = 1;
  localparam int unsigned T_EXEC      = 5;
  localparam int unsigned T_EXEC_LONG = 20;
  localparam int unsigned CNT_W       = 17;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic       cmd_rw;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_data_out;
  logic       LCD_data_oe;
  logic [7:0] LCD_data_in;

  lcd_bus_sequencer #(
    .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H),
    .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_data_out(LCD_data_out), .LCD_data_oe(LCD_data_oe),
    .LCD_data_in(LCD_data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rs;
    bit         rw;
    logic [7:0] data;
    logic [7:0] bus;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] bus_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  // Execution wait implied by the command type
  function automatic int exec_of(exp_t x);
    if (!x.rs && x.rw) return 0;
    if (!x.rs && !x.rw && x.data >= 8'd1 && x.data <= 8'd3) return int'(T_EXEC_LONG);
    return int'(T_EXEC);
  endfunction

  // LCD device: presents the queued read byte only while E is high for a read
  initial begin
    logic       e_prev;
    logic [7:0] cur_bus;
    e_prev      = 1'b0;
    cur_bus     = 8'h00;
    LCD_data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (LCD_E && LCD_RW) begin
        if (!e_prev && bus_q.size() > 0) cur_bus = bus_q.pop_front();
        LCD_data_in = cur_bus;
      end else begin
        LCD_data_in = ~cur_bus;
      end
      e_prev = LCD_E;
    end
  end

  // Monitor: e counts edges since the accepting edge of the current transfer
  initial begin
    exp_t        cur;
    bit          active;
    bit          hs;
    int          e;
    int          total;
    logic [13:0] ev;
    logic [13:0] av;
    cur    = '{1'b0, 1'b0, 8'h00, 8'h00};
    active = 1'b0;
    e      = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        active = 1'b0;
        cur    = '{1'b0, 1'b0, 8'h00, 8'h00};
        continue;
      end
      total = int'(T_AS + T_PW + T_H) + exec_of(cur);
      if (active && e < total) begin
        ev = {1'b0, (e >= int'(T_AS) && e < int'(T_AS + T_PW)), ~cur.rw, cur.rs, cur.rw,
              cur.data, (cur.rw && e == int'(T_AS + T_PW))};
      end else begin
        ev = {1'b1, 1'b0, 1'b0, cur.rs, cur.rw, cur.data, 1'b0};
      end
      av = {cmd_ready, LCD_E, LCD_data_oe, LCD_RS, LCD_RW, LCD_data_out, rsp_valid};
      chk("pins{rdy,E,oe,RS,RW,dout,rspv}", 32'(av), 32'(ev));
      if (ev[0]) chk("rsp_data", 32'(rsp_data), 32'(cur.bus));
      hs = cmd_valid && cmd_ready;
      @(posedge clk);
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 32'(exp_q.size()), 32'd1);
        end else begin
          cur    = exp_q.pop_front();
          active = 1'b1;
          e      = 0;
        end
      end else if (active && e < 1000) begin
        e++;
      end
    end
  end

  // Offer one transfer; returns just after the accepting edge
  task automatic issue(input bit rs, input bit rw, input logic [7:0] d, input bit hold);
    exp_t       x;
    logic [7:0] b;
    bit         acc;
    b   = 8'($urandom);
    acc = 1'b0;
    @(negedge clk);
    x = '{rs, rw, d, b};
    exp_q.push_back(x);
    if (rw) bus_q.push_back(b);
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_rw    = rw;
    cmd_data  = d;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (cmd_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_rs    = 1'($urandom);
      cmd_rw    = 1'($urandom);
      cmd_data  = 8'($urandom);
    end
  endtask

  task automatic all_outputs_zero(input string nm);
    chk(nm, 32'({cmd_ready, LCD_E, LCD_data_oe, LCD_RS, LCD_RW, LCD_data_out,
                 rsp_valid, rsp_data}), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_rs    = 1'b0;
    cmd_rw    = 1'b0;
    cmd_data  = 8'h00;
    #1;
    all_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_before_first_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("ready_after_first_edge", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    mon_en = 1'b1;

    // Directed transfers
    issue(1'b1, 1'b0, 8'h41, 1'b0);
    issue(1'b0, 1'b0, 8'h01, 1'b0);
    issue(1'b0, 1'b0, 8'h03, 1'b0);
    issue(1'b0, 1'b0, 8'h04, 1'b0);
    issue(1'b0, 1'b0, 8'h02, 1'b0);
    issue(1'b0, 1'b1, 8'h00, 1'b0);
    issue(1'b1, 1'b1, 8'h00, 1'b0);

    // Held valid with data changed mid-transfer, then back-to-back
    issue(1'b1, 1'b0, 8'h33, 1'b1);
    issue(1'b1, 1'b0, 8'hC4, 1'b1);
    issue(1'b0, 1'b1, 8'h55, 1'b0);

    // Reset during the second PULSE cycle of a write
    issue(1'b1, 1'b0, 8'h7E, 1'b0);
    repeat (int'(T_AS) + 1) @(negedge clk);
    mon_en = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    all_outputs_zero("reset_mid_pulse");
    exp_q.delete();
    bus_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_release_pre_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("after_release{rdy,E,oe,rspv}", 32'({cmd_ready, LCD_E, LCD_data_oe, rsp_valid}),
        32'b1000);
    @(negedge clk);
    mon_en = 1'b1;

    // Randomized transfers; small data values often hit the long-exec range
    for (int n = 0; n < 40; n++) begin
      bit         rs;
      bit         rw;
      bit         hold;
      logic [7:0] d;
      rs   = 1'($urandom);
      rw   = 1'($urandom);
      d    = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      hold = (n != 39) && ($urandom_range(0, 3) == 0);
      issue(rs, rw, d, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #2;
      if (cmd_ready) break;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
